// File: rtl/vector_ctrl_pkg.sv
// Shared definitions for the vector control register file: promoted register
// indices, sequencer states and the default matmul mask width.
package vector_ctrl_pkg;

  localparam int VC_VL          = 0;
  localparam int VC_MM_BCOLS    = 29;
  localparam int VC_MM_ACOLS    = 30;
  localparam int VC_MM_AROWS    = 31;
  localparam int VC_MATMUL_SIZE = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } vc_state_e;

endpackage

// File: rtl/vregfile_rdport.sv
// One registered read port: 1-cycle latency, same-cycle write bypass, holds
// its value while disabled and returns zero for clears and out-of-range reads.
module vregfile_rdport
  import vector_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_reg,
  input  logic             addr_ok,
  input  logic [WIDTH-1:0] arr_data,
  input  logic             clear,
  input  logic             wr_fire,
  input  logic [AW-1:0]    wr_reg,
  input  logic [WIDTH-1:0] wr_val,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] rd_data_d, rd_data_q;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      if (clear || !addr_ok) begin
        rd_data_d = '0;
      end else if (wr_fire && (wr_reg == rd_reg)) begin
        rd_data_d = wr_val;
      end else begin
        rd_data_d = arr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/vregfile_control_mp.sv
// Vector control register file: one write port, NUMRDPORTS read ports,
// promoted vl / matmul mask registers and a hardware clear sequencer.
//
// state    | meaning
// ST_IDLE  | normal operation, writes and reads serviced
// ST_CLEAR | zeroing array[idx] one entry per cycle, writes ignored
module vregfile_control_mp
  import vector_ctrl_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int NUMREGS     = 32,
  parameter int LOG2NUMREGS = 5,
  parameter int NUMRDPORTS  = 2,
  parameter int MATMUL_SIZE = VC_MATMUL_SIZE,
  parameter int MAXVL       = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUMRDPORTS-1:0]             rd_en,
  input  logic [NUMRDPORTS*LOG2NUMREGS-1:0] rd_reg,
  output logic [NUMRDPORTS*WIDTH-1:0]       rd_data,
  input  logic [LOG2NUMREGS-1:0]            wr_reg,
  input  logic [WIDTH-1:0]                  wr_data,
  input  logic                              wr_we,
  input  logic                              clr_start,
  output logic                              clr_busy,
  output logic [WIDTH-1:0]                  vl,
  output logic [3*MATMUL_SIZE-1:0]          matmul_masks
);

  localparam logic [LOG2NUMREGS:0]   NUMREGS_W = (LOG2NUMREGS+1)'(NUMREGS);
  localparam logic [LOG2NUMREGS-1:0] LAST_IDX  = LOG2NUMREGS'(NUMREGS - 1);
  localparam logic [LOG2NUMREGS-1:0] A_VL      = LOG2NUMREGS'(VC_VL);
  localparam logic [LOG2NUMREGS-1:0] A_BCOLS   = LOG2NUMREGS'(VC_MM_BCOLS);
  localparam logic [LOG2NUMREGS-1:0] A_ACOLS   = LOG2NUMREGS'(VC_MM_ACOLS);
  localparam logic [LOG2NUMREGS-1:0] A_AROWS   = LOG2NUMREGS'(VC_MM_AROWS);
  localparam logic [WIDTH-1:0]       MAXVL_W   = WIDTH'(MAXVL);

  vc_state_e                state_d, state_q;
  logic [LOG2NUMREGS-1:0]   idx_d, idx_q;
  logic [WIDTH-1:0]         mem_d [NUMREGS];
  logic [WIDTH-1:0]         mem_q [NUMREGS];
  logic [WIDTH-1:0]         vl_d, vl_q;
  logic [MATMUL_SIZE-1:0]   arows_d, arows_q, acols_d, acols_q, bcols_d, bcols_q;

  logic             wr_ok, wr_fire;
  logic [WIDTH-1:0] wr_val;

  assign wr_ok   = ({1'b0, wr_reg} < NUMREGS_W);
  // A clear request in the same cycle wins over a write; the sequencer wipes the array anyway.
  assign wr_fire = (state_q == ST_IDLE) && !clr_start && wr_we && wr_ok;
  assign wr_val  = ((wr_reg == A_VL) && (wr_data > MAXVL_W)) ? MAXVL_W : wr_data;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mem_d   = mem_q;
    vl_d    = vl_q;
    arows_d = arows_q;
    acols_d = acols_q;
    bcols_d = bcols_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
          vl_d    = '0;
          arows_d = '1;
          acols_d = '1;
          bcols_d = '1;
        end else if (wr_fire) begin
          mem_d[wr_reg] = wr_val;
          if (wr_reg == A_VL)    vl_d    = wr_val;
          if (wr_reg == A_AROWS) arows_d = wr_data[MATMUL_SIZE-1:0];
          if (wr_reg == A_ACOLS) acols_d = wr_data[MATMUL_SIZE-1:0];
          if (wr_reg == A_BCOLS) bcols_d = wr_data[MATMUL_SIZE-1:0];
        end
      end
      ST_CLEAR: begin
        mem_d[idx_q] = '0;
        idx_d        = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      idx_q   <= '0;
      vl_q    <= '0;
      arows_q <= '1;
      acols_q <= '1;
      bcols_q <= '1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vl_q    <= vl_d;
      arows_q <= arows_d;
      acols_q <= acols_d;
      bcols_q <= bcols_d;
    end
  end

  // Storage has no reset; the clear sequence that follows every reset zeroes it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  for (genvar p = 0; p < NUMRDPORTS; p++) begin : g_rd
    logic [LOG2NUMREGS-1:0] addr;
    logic                   addr_ok;
    logic [WIDTH-1:0]       arr_word;

    assign addr     = rd_reg[p*LOG2NUMREGS +: LOG2NUMREGS];
    assign addr_ok  = ({1'b0, addr} < NUMREGS_W);
    assign arr_word = addr_ok ? mem_q[addr] : '0;

    vregfile_rdport #(
      .WIDTH (WIDTH),
      .AW    (LOG2NUMREGS)
    ) u_rdport (
      .clk      (clk),
      .reset    (reset),
      .rd_en    (rd_en[p]),
      .rd_reg   (addr),
      .addr_ok  (addr_ok),
      .arr_data (arr_word),
      .clear    (state_q == ST_CLEAR),
      .wr_fire  (wr_fire),
      .wr_reg   (wr_reg),
      .wr_val   (wr_val),
      .rd_data  (rd_data[p*WIDTH +: WIDTH])
    );
  end

  assign clr_busy     = (state_q == ST_CLEAR);
  assign vl           = vl_q;
  assign matmul_masks = {bcols_q, acols_q, arows_q};

endmodule

// File: tb/tb_vregfile_control_mp.sv
// Self-checking bench for vregfile_control_mp: directed steps plus a random
// phase, checked every cycle against a behavioural register-file model.
module tb_vregfile_control_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rd_en;
  logic [9:0]  rd_reg;
  logic [63:0] rd_data;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic        wr_we;
  logic        clr_start;
  logic        clr_busy;
  logic [31:0] vl;
  logic [23:0] matmul_masks;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int          busy_left;
  logic [31:0] m_mem [32];
  logic [31:0] m_vl;
  logic [7:0]  m_arows, m_acols, m_bcols;
  logic [31:0] m_rd [2];

  vregfile_control_mp dut (
    .clk          (clk),
    .reset        (reset),
    .rd_en        (rd_en),
    .rd_reg       (rd_reg),
    .rd_data      (rd_data),
    .wr_reg       (wr_reg),
    .wr_data      (wr_data),
    .wr_we        (wr_we),
    .clr_start    (clr_start),
    .clr_busy     (clr_busy),
    .vl           (vl),
    .matmul_masks (matmul_masks)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, updating the model from the inputs applied this cycle.
  task automatic tick();
    logic [31:0] wv;
    bit          wfire;
    int          a;
    if (reset) begin
      busy_left = 32;
      m_vl = 0;
      m_arows = 8'hFF; m_acols = 8'hFF; m_bcols = 8'hFF;
      m_rd[0] = 0; m_rd[1] = 0;
    end else if (busy_left > 0) begin
      for (int p = 0; p < 2; p++) if (rd_en[p]) m_rd[p] = 0;
      m_mem[32 - busy_left] = 0;
      busy_left--;
    end else begin
      wfire = wr_we && !clr_start;
      wv = (wr_reg == 0 && wr_data > 32'd64) ? 32'd64 : wr_data;
      for (int p = 0; p < 2; p++) begin
        if (rd_en[p]) begin
          a = int'(rd_reg[p*5 +: 5]);
          m_rd[p] = (wfire && int'(wr_reg) == a) ? wv : m_mem[a];
        end
      end
      if (clr_start) begin
        busy_left = 32;
        m_vl = 0;
        m_arows = 8'hFF; m_acols = 8'hFF; m_bcols = 8'hFF;
      end else if (wfire) begin
        m_mem[wr_reg] = wv;
        case (wr_reg)
          5'd0:  m_vl = wv;
          5'd31: m_arows = wr_data[7:0];
          5'd30: m_acols = wr_data[7:0];
          5'd29: m_bcols = wr_data[7:0];
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all();
    check("busy",  {63'd0, clr_busy}, {63'd0, (busy_left > 0)});
    check("vl",    {32'd0, vl}, {32'd0, m_vl});
    check("masks", {40'd0, matmul_masks}, {40'd0, m_bcols, m_acols, m_arows});
    check("rd0",   {32'd0, rd_data[31:0]},  {32'd0, m_rd[0]});
    check("rd1",   {32'd0, rd_data[63:32]}, {32'd0, m_rd[1]});
  endtask

  function automatic logic [4:0] pick();
    case ($urandom_range(0, 9))
      0: return 5'd0;
      1: return 5'd29;
      2: return 5'd30;
      3: return 5'd31;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic count_busy(input string tag);
    int cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (clr_busy) cnt++;
      tick();
      check_all();
    end
    check(tag, 64'(cnt), 64'd32);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = 0;
    busy_left = 0;
    m_vl = 0; m_arows = 0; m_acols = 0; m_bcols = 0;
    m_rd[0] = 0; m_rd[1] = 0;
    reset = 1; rd_en = 0; rd_reg = 0; wr_reg = 0; wr_data = 0; wr_we = 0; clr_start = 0;

    // reset and power-on clear
    tick();
    check_all();
    check("rst_vl", {32'd0, vl}, 64'd0);
    check("rst_masks", {40'd0, matmul_masks}, 64'hFFFFFF);
    reset = 0;
    rd_en = 2'b11; rd_reg = {5'd3, 5'd17};
    count_busy("rst_busy_len");

    for (int a = 0; a < 32; a++) begin
      rd_reg = {5'(a), 5'(a)};
      tick();
      check_all();
    end

    // vl clamping
    rd_en = 2'b00;
    wr_we = 1; wr_reg = 0; wr_data = 40;
    tick(); check_all();
    check("vl40", {32'd0, vl}, 64'd40);
    wr_data = 100;
    tick(); check_all();
    check("vl_clamp", {32'd0, vl}, 64'd64);
    wr_we = 0; rd_en = 2'b01; rd_reg = 0;
    tick(); check_all();
    check("rd_vl", {32'd0, rd_data[31:0]}, 64'd64);

    // matmul masks
    rd_en = 0; wr_we = 1;
    wr_reg = 31; wr_data = 32'h1F3; tick(); check_all();
    wr_reg = 30; wr_data = 32'h0F;  tick(); check_all();
    wr_reg = 29; wr_data = 32'hAA;  tick(); check_all();
    check("masks_val", {40'd0, matmul_masks}, 64'hAA0FF3);
    wr_we = 0; rd_en = 2'b10; rd_reg = {5'd31, 5'd0};
    tick(); check_all();
    check("rd_r31", {32'd0, rd_data[63:32]}, 64'h1F3);

    // same-cycle bypass on both ports, then hold
    wr_we = 1; wr_reg = 5; wr_data = 32'hDEAD; rd_en = 2'b11; rd_reg = {5'd5, 5'd5};
    tick(); check_all();
    check("byp0", {32'd0, rd_data[31:0]}, 64'hDEAD);
    check("byp1", {32'd0, rd_data[63:32]}, 64'hDEAD);
    wr_we = 1; wr_data = 32'hBEEF; rd_en = 2'b00;
    tick(); check_all();
    check("hold0", {32'd0, rd_data[31:0]}, 64'hDEAD);
    wr_we = 0;

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      rd_en = 2'($urandom_range(0, 3));
      rd_reg = {pick(), pick()};
      wr_we = 1'($urandom_range(0, 1));
      wr_reg = pick();
      wr_data = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 130)) : $urandom;
      clr_start = ($urandom_range(0, 60) == 0);
      tick();
      check_all();
    end
    clr_start = 0; wr_we = 0; rd_en = 0;
    for (int i = 0; i < 34; i++) begin tick(); check_all(); end

    // clear with write attempt and mid-clear restart request
    wr_we = 1; wr_reg = 7; wr_data = 32'h1234;
    tick(); check_all();
    wr_we = 0; clr_start = 1;
    tick(); check_all();
    clr_start = 0; wr_we = 1; wr_data = 32'h5;
    tick(); check_all();
    wr_we = 0;
    for (int i = 0; i < 8; i++) begin tick(); check_all(); end
    clr_start = 1;
    tick(); check_all();
    clr_start = 0;
    for (int i = 0; i < 30; i++) begin tick(); check_all(); end
    check("clr_done", {63'd0, clr_busy}, 64'd0);
    rd_en = 2'b01; rd_reg = {5'd0, 5'd7};
    tick(); check_all();
    check("r7_cleared", {32'd0, rd_data[31:0]}, 64'd0);

    // reset at clear index 10
    rd_en = 0; clr_start = 1;
    tick(); check_all();
    clr_start = 0;
    for (int i = 0; i < 10; i++) begin tick(); check_all(); end
    reset = 1;
    tick(); check_all();
    reset = 0;
    count_busy("rst_mid_busy_len");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
